// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with parity/framing checks and one-cycle valid pulse.
// Optional 3-tap majority glitch filter on the synchronized line: define UART_RX_GLITCH_FILTER_EN.
`ifndef UART_NUMB_DIV_CLK_WD
`define UART_NUMB_DIV_CLK_WD 16
`endif
`ifndef UART_NUMB_BIT_WD
`define UART_NUMB_BIT_WD 4
`endif
`ifndef UART_NUMB_BIT_MAX
`define UART_NUMB_BIT_MAX 8
`endif
`ifndef UART_ENUM_PARITY_WD
`define UART_ENUM_PARITY_WD 2
`endif
`ifndef UART_SIZE_STOP_WD
`define UART_SIZE_STOP_WD 1
`endif

module uart_rx (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [`UART_NUMB_DIV_CLK_WD-1:0]  cfg_num_div_clk_i,
  input  logic [`UART_NUMB_BIT_WD-1:0]      cfg_num_bit_i,
  input  logic [`UART_ENUM_PARITY_WD-1:0]   cfg_enm_parity_i,
  input  logic [`UART_SIZE_STOP_WD-1:0]     cfg_siz_stop_i,
  input  logic                              uart_rx_i,
  output logic                              val_o,
  output logic [`UART_NUMB_BIT_MAX-1:0]     dat_o,
  output logic                              err_parity_o,
  output logic                              err_frame_o,
  output logic                              busy_o
);

  localparam int DIV_W  = `UART_NUMB_DIV_CLK_WD;
  localparam int NB_W   = `UART_NUMB_BIT_WD;
  localparam int DATA_W = `UART_NUMB_BIT_MAX;
  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(4)) ? DIV_W'(4) : d;
  endfunction

  function automatic logic [NB_W-1:0] clamp_nbit(input logic [NB_W-1:0] n);
    if (n > NB_W'(DATA_W)) return NB_W'(DATA_W);
    if (n < NB_W'(5))      return NB_W'(5);
    return n;
  endfunction

  state_t              state;
  logic                sync_p0, sync_p1, rx_s, rx_prev;
  logic [DIV_W-1:0]    div_q, cnt;
  logic [NB_W-1:0]     nbit_q, bit_idx;
  logic                par_en_q, par_odd_q, two_stop_q, stop_idx;
  logic [DATA_W-1:0]   shreg;
  logic                perr_q, ferr_q;
  logic                bit_tick;

  // Stage p0/p1: two-flop synchronizer (plus optional majority filter taps)
`ifdef UART_RX_GLITCH_FILTER_EN
  logic filt_p2, filt_p3;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      filt_p2 <= 1'b1;
      filt_p3 <= 1'b1;
    end else begin
      sync_p0 <= uart_rx_i;
      sync_p1 <= sync_p0;
      filt_p2 <= sync_p1;
      filt_p3 <= filt_p2;
    end
  end

  assign rx_s = (sync_p1 & filt_p2) | (sync_p1 & filt_p3) | (filt_p2 & filt_p3);
`else
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= uart_rx_i;
      sync_p1 <= sync_p0;
    end
  end

  assign rx_s = sync_p1;
`endif

  assign bit_tick = (cnt == div_q - DIV_W'(1));

  // Stage: edge register and frame FSM with registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      rx_prev      <= 1'b1;
      cnt          <= '0;
      div_q        <= DIV_W'(4);
      nbit_q       <= NB_W'(5);
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      two_stop_q   <= 1'b0;
      stop_idx     <= 1'b0;
      bit_idx      <= '0;
      shreg        <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      val_o        <= 1'b0;
      dat_o        <= '0;
      err_parity_o <= 1'b0;
      err_frame_o  <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      rx_prev <= rx_s;
      val_o   <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_s) begin
            state      <= START;
            busy_o     <= 1'b1;
            div_q      <= clamp_div(cfg_num_div_clk_i);
            nbit_q     <= clamp_nbit(cfg_num_bit_i);
            par_en_q   <= (cfg_enm_parity_i == `UART_ENUM_PARITY_WD'(1)) ||
                          (cfg_enm_parity_i == `UART_ENUM_PARITY_WD'(2));
            par_odd_q  <= (cfg_enm_parity_i == `UART_ENUM_PARITY_WD'(1));
            two_stop_q <= |cfg_siz_stop_i;
            shreg      <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
          end
        end
        START: begin
          if (cnt == (div_q >> 1)) begin
            cnt <= '0;
            if (rx_s) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        DATA: begin
          if (bit_tick) begin
            cnt                    <= '0;
            shreg[bit_idx[IDX_W-1:0]] <= rx_s;
            bit_idx                <= bit_idx + NB_W'(1);
            if (bit_idx == nbit_q - NB_W'(1))
              state <= par_en_q ? PARITY : STOP;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        PARITY: begin
          if (bit_tick) begin
            cnt    <= '0;
            perr_q <= ((^shreg) ^ rx_s) != par_odd_q;
            state  <= STOP;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        STOP: begin
          if (bit_tick) begin
            cnt <= '0;
            if (!rx_s) ferr_q <= 1'b1;
            if (stop_idx == two_stop_q) begin
              state        <= IDLE;
              busy_o       <= 1'b0;
              val_o        <= 1'b1;
              dat_o        <= shreg;
              err_parity_o <= perr_q;
              err_frame_o  <= ferr_q | !rx_s;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed, table-driven bench for uart_rx: frame formats, errors, break, false start, back-to-back, mid-frame events.
`timescale 1ns/1ps
module tb_uart_rx;

`ifdef UART_RX_GLITCH_FILTER_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] cfg_div = 16'd16;
  logic [3:0]  cfg_nb = 4'd8;
  logic [1:0]  cfg_par = 2'd0;
  logic [0:0]  cfg_stop = 1'b0;
  logic        line = 1'b1;
  logic        val_o;
  logic [7:0]  dat_o;
  logic        err_parity_o, err_frame_o, busy_o;

  uart_rx dut (
    .clk               (clk),
    .rstn              (rstn),
    .cfg_num_div_clk_i (cfg_div),
    .cfg_num_bit_i     (cfg_nb),
    .cfg_enm_parity_i  (cfg_par),
    .cfg_siz_stop_i    (cfg_stop),
    .uart_rx_i         (line),
    .val_o             (val_o),
    .dat_o             (dat_o),
    .err_parity_o      (err_parity_o),
    .err_frame_o       (err_frame_o),
    .busy_o            (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int         n_val = 0;
  logic [7:0] m_dat = '0;
  logic       m_perr = 1'b0, m_ferr = 1'b0;
  int         m_cyc = 0;
  logic [9:0] hist[$];

  always @(negedge clk) begin
    if (val_o) begin
      n_val++;
      m_dat  = dat_o;
      m_perr = err_parity_o;
      m_ferr = err_frame_o;
      m_cyc  = cyc;
      hist.push_back({err_parity_o, err_frame_o, dat_o});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int fall_cyc = 0;

  // Called at a negedge; returns at the negedge ending the last stop bit with the line high.
  task automatic tx_frame(input int div, input int nb, input int par, input int stp,
                          input logic [7:0] d, input bit flip, input bit bad_stop);
    logic [7:0] m;
    logic       pb;
    m  = 8'((1 << nb) - 1);
    pb = (^(d & m)) ^ (par == 1);
    if (flip) pb = ~pb;
    line = 1'b0;
    fall_cyc = cyc;
    repeat (div) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      line = d[i];
      repeat (div) @(negedge clk);
    end
    if (par == 1 || par == 2) begin
      line = pb;
      repeat (div) @(negedge clk);
    end
    for (int s = 0; s < ((stp != 0) ? 2 : 1); s++) begin
      line = bad_stop ? 1'b0 : 1'b1;
      repeat (div) @(negedge clk);
    end
    line = 1'b1;
  endtask

  typedef struct {
    int         div_cfg;
    int         div_tx;
    int         nb;
    int         par;
    int         stp;
    logic [7:0] data;
    bit         flip;
    bit         bad_stop;
    logic [7:0] e_dat;
    bit         e_perr;
    bit         e_ferr;
    int         e_lat;
  } vec_t;

  localparam int NV = 10;
  vec_t vec [NV];

  int n0, bt, b14;

  initial begin
    vec[0] = '{16, 16, 8, 0, 0, 8'hA5, 0, 0, 8'hA5, 0, 0, 156};
    vec[1] = '{16, 16, 7, 2, 1, 8'h35, 0, 0, 8'h35, 0, 0, 172};
    vec[2] = '{16, 16, 7, 2, 1, 8'h35, 1, 0, 8'h35, 1, 0, 172};
    vec[3] = '{16, 16, 5, 1, 0, 8'h1F, 0, 0, 8'h1F, 0, 0, 124};
    vec[4] = '{ 2,  4, 8, 0, 0, 8'h3C, 0, 0, 8'h3C, 0, 0,  42};
    vec[5] = '{ 8,  8, 8, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0,  88};
    vec[6] = '{ 8,  8, 8, 2, 0, 8'hFF, 1, 0, 8'hFF, 1, 0,  88};
    vec[7] = '{ 8,  8, 8, 0, 0, 8'h81, 0, 1, 8'h81, 0, 1,  80};
    vec[8] = '{10, 10, 6, 0, 1, 8'h2A, 0, 0, 8'h2A, 0, 0,  89};
    vec[9] = '{16, 16, 8, 3, 0, 8'h5A, 0, 0, 8'h5A, 0, 0, 156};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_val", 32'(val_o), 0);
    chk("rst_dat", 32'(dat_o), 0);
    chk("rst_perr", 32'(err_parity_o), 0);
    chk("rst_ferr", 32'(err_frame_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < NV; i++) begin
      cfg_div  = 16'(vec[i].div_cfg);
      cfg_nb   = 4'(vec[i].nb);
      cfg_par  = 2'(vec[i].par);
      cfg_stop = (vec[i].stp != 0);
      n0 = n_val;
      @(negedge clk);
      tx_frame(vec[i].div_tx, vec[i].nb, vec[i].par, vec[i].stp, vec[i].data,
               vec[i].flip, vec[i].bad_stop);
      repeat (2 * vec[i].div_tx + 8) @(negedge clk);
      chk($sformatf("v%0d_count", i), 32'(n_val - n0), 1);
      chk($sformatf("v%0d_dat", i), 32'(m_dat), 32'(vec[i].e_dat));
      chk($sformatf("v%0d_perr", i), 32'(m_perr), 32'(vec[i].e_perr));
      chk($sformatf("v%0d_ferr", i), 32'(m_ferr), 32'(vec[i].e_ferr));
      chk($sformatf("v%0d_lat", i), 32'(m_cyc - fall_cyc), 32'(vec[i].e_lat + LAT));
      chk($sformatf("v%0d_hold", i), 32'(dat_o), 32'(vec[i].e_dat));
    end

    // False start: 3-cycle low pulse, div 16
    cfg_div = 16'd16; cfg_nb = 4'd8; cfg_par = 2'd0; cfg_stop = 1'b0;
    n0 = n_val; bt = -1; b14 = -1;
    @(negedge clk);
    line = 1'b0;
    fall_cyc = cyc;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 2) line = 1'b1;
      if (busy_o && bt < 0) bt = cyc - fall_cyc;
      if (cyc - fall_cyc == 14) b14 = busy_o;
    end
    chk("fs_busy_rise", 32'(bt), 32'(3 + LAT));
    chk("fs_busy_mid", 32'(b14), 0);
    chk("fs_no_val", 32'(n_val - n0), 0);

    // Break: line low for 40 bit times in 8N1
    n0 = n_val;
    line = 1'b0;
    repeat (640) @(negedge clk);
    line = 1'b1;
    repeat (64) @(negedge clk);
    chk("brk_count", 32'(n_val - n0), 1);
    chk("brk_ferr", 32'(m_ferr), 1);
    chk("brk_perr", 32'(m_perr), 0);
    chk("brk_dat", 32'(m_dat), 0);
    n0 = n_val;
    tx_frame(16, 8, 0, 0, 8'h3C, 0, 0);
    repeat (40) @(negedge clk);
    chk("brk_next_count", 32'(n_val - n0), 1);
    chk("brk_next_dat", 32'(m_dat), 32'h3C);
    chk("brk_next_ferr", 32'(m_ferr), 0);

    // Back-to-back, zero idle gap, div 4
    cfg_div = 16'd4;
    hist.delete();
    @(negedge clk);
    tx_frame(4, 8, 0, 0, 8'h00, 0, 0);
    tx_frame(4, 8, 0, 0, 8'hFF, 0, 0);
    tx_frame(4, 8, 0, 0, 8'h5A, 0, 0);
    repeat (30) @(negedge clk);
    chk("b2b_count", 32'(hist.size()), 3);
    if (hist.size() == 3) begin
      chk("b2b_0", 32'(hist[0]), 32'h000);
      chk("b2b_1", 32'(hist[1]), 32'h0FF);
      chk("b2b_2", 32'(hist[2]), 32'h05A);
    end

    // Config change mid-frame: frame stays 8-bit
    cfg_div = 16'd16; cfg_nb = 4'd8;
    n0 = n_val;
    @(negedge clk);
    fork
      tx_frame(16, 8, 0, 0, 8'hC3, 0, 0);
      begin
        repeat (60) @(negedge clk);
        cfg_nb = 4'd6;
      end
    join
    repeat (40) @(negedge clk);
    chk("cfg_count", 32'(n_val - n0), 1);
    chk("cfg_dat", 32'(m_dat), 32'hC3);
    chk("cfg_lat", 32'(m_cyc - fall_cyc), 32'(156 + LAT));
    cfg_nb = 4'd8;

    // Reset during a DATA bit
    n0 = n_val;
    @(negedge clk);
    fork
      tx_frame(16, 8, 0, 0, 8'h77, 0, 0);
      begin
        repeat (60) @(negedge clk);
        chk("mr_busy_before", 32'(busy_o), 1);
        rstn = 1'b0;
        #1;
        chk("mr_val", 32'(val_o), 0);
        chk("mr_dat", 32'(dat_o), 0);
        chk("mr_perr", 32'(err_parity_o), 0);
        chk("mr_ferr", 32'(err_frame_o), 0);
        chk("mr_busy", 32'(busy_o), 0);
      end
    join
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("mr_no_val", 32'(n_val - n0), 0);
    n0 = n_val;
    tx_frame(16, 8, 0, 0, 8'h96, 0, 0);
    repeat (40) @(negedge clk);
    chk("mr_next_count", 32'(n_val - n0), 1);
    chk("mr_next_dat", 32'(m_dat), 32'h96);
    chk("mr_next_err", 32'({m_perr, m_ferr}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive engine for the UART subsystem. It sits directly downstream of the transmit path and consumes the serial line that `uart_tx_with_apb` drives. It takes the same runtime configuration as the transmitter: clock divider, data bits, parity and stop size. It oversamples the line, recovers each character and presents it as a one-cycle valid/data pulse with parity and framing error flags, ready to feed an RX FIFO and `uart_reg` feedback.

## Interface
Parameters: none. All widths come from `define_uart.vh`.

Ports:
- `clk`  in  1  system clock
- `rstn`  in  1  reset; asynchronous, active-low
- `cfg_num_div_clk_i`  in  `UART_NUMB_DIV_CLK_WD`  clock cycles per bit (baud divider)
- `cfg_num_bit_i`  in  `UART_NUMB_BIT_WD`  data bits per character, 5..`UART_NUMB_BIT_MAX`
- `cfg_enm_parity_i`  in  `UART_ENUM_PARITY_WD`  0 none, 1 odd, 2 even, 3 treated as none
- `cfg_siz_stop_i`  in  `UART_SIZE_STOP_WD`  0 one stop bit, nonzero two stop bits
- `uart_rx_i`  in  1  asynchronous serial line, idle high
- `val_o`  out  1  one-cycle pulse: character received
- `dat_o`  out  `UART_NUMB_BIT_MAX`  received character, LSB-aligned, unused MSBs zero
- `err_parity_o`  out  1  parity mismatch; qualified by `val_o`
- `err_frame_o`  out  1  a stop bit sampled low; qualified by `val_o`
- `busy_o`  out  1  frame in progress (state != IDLE)

## Operation
- **Input conditioning:** `uart_rx_i` passes through a 2-flop synchronizer, reset to 1. Output is `rx_s`.
- **Configuration latch:** all `cfg_*` inputs are latched on start-edge detection and held for the whole frame. Changes mid-frame take effect from the next frame.
- **Divider handling:** a divider below 4 is clamped to 4.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: a falling edge on `rx_s` (previous 1, current 0) goes to START and clears the bit counter `cnt`.
  - START: at `cnt == div>>1` (mid-bit), `rx_s==1` is a false start and returns to IDLE. `rx_s==0` clears `cnt` and goes to DATA.
  - DATA: sample `rx_s` every `div` cycles, LSB first, into a shift register. After `cfg_num_bit` samples, go to PARITY if parity is enabled, otherwise STOP.
  - PARITY: one sample. Odd requires XOR(data, parity bit) = 1; even requires it to be 0.
  - STOP: one or two samples. Any low sample sets the frame error. After the last stop sample, pulse `val_o` and return to IDLE.
- **Re-arm:** back in IDLE, a new frame needs a fresh falling edge. A line held low (break) therefore yields exactly one frame-error character, then silence until the line returns high.
- **Output hold:** `dat_o` and the error flags are registered and hold their values until the next `val_o`.

## Timing
- **Reset values:** `val_o`=0, `dat_o`=0, `err_parity_o`=0, `err_frame_o`=0, `busy_o`=0. FSM in IDLE, synchronizer flops at 1.
- **Start detection:** `busy_o` rises 3 cycles after the line falls (2 sync stages + edge register).
- **Sample points:** bit n (start = 0) is sampled `div>>1 + n*div` cycles after start detection.
- **Output latency:** `val_o` rises 1 cycle after the final stop-bit sample. `busy_o` falls in the same cycle.
- **Output pulse:** `val_o` is exactly one cycle wide. There is no back-pressure; the consumer must accept it.
- **Reset mid-frame:** outputs clear immediately, the FSM returns to IDLE and the partial character is discarded, with no `val_o`.
- **Back-to-back frames:** a falling edge arriving in the cycle the FSM re-enters IDLE is detected. Zero idle gap beyond the stop bits is supported.

## Configuration
- **`UART_RX_GLITCH_FILTER_EN` defined:** a 3-tap majority filter follows the synchronizer. `rx_s` is the majority of the last 3 synchronized samples, so single-cycle glitches are rejected. All latencies above grow by 1 cycle.
- **Not defined:** `rx_s` is the synchronizer output directly. A 1-cycle low glitch enters START and is rejected there as a false start.

## Test plan
- **8N1 basic:** div=16, 8 bits, no parity, 1 stop; send 0xA5 → one `val_o` pulse with `dat_o`=0xA5, both errors 0, `val_o` at 9.5×16 + 4 cycles after the line falls (filter off).
- **7E2 and 5O1 parity:** 7E2 with 0x35 and correct parity → no error. Same character with the parity bit flipped → `err_parity_o`=1, `dat_o`=0x35. 5O1 with 0x1F → `dat_o`=0x1F, upper bits 0.
- **Frame error / break:** line held low for 40 bit times (8N1) → exactly one `val_o` with `err_frame_o`=1 and `dat_o`=0x00. No further pulses until the line returns high and a new start arrives.
- **False start:** 3-cycle low pulse, div=16 → no `val_o`, `busy_o` back to 0 by mid-bit. With `UART_RX_GLITCH_FILTER_EN`, a 1-cycle pulse never raises `busy_o`.
- **Back-to-back, loopback:** drive from `uart_tx_with_apb` `uart_tx_o`, writing 0x00, 0xFF, 0x5A with div=4 → three pulses in order, data exact, no errors.
- **Config change and reset mid-frame:** change `cfg_num_bit_i` from 8 to 6 mid-frame → the current frame still completes as 8-bit. Assert `rstn` during a DATA bit → all outputs 0 at once, no `val_o`, and the next frame is received correctly.
